// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional write-to-read
// bypass and a per-register busy scoreboard for in-flight multi-cycle producers.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    output logic                rsv_stall,
    output logic [AW:0]         busy_cnt
);

    logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d, wr_data;
    logic [NREGS-1:0]           busy_q, busy_d, busy_w, wr_hit;
    logic [AW:0]                cnt_q, cnt_d;
    logic                       rsv_ok;

    // Per-register write decode; later ports overwrite earlier ones so the
    // highest-index port wins on address collisions.
    always_comb begin
        wr_hit  = '0;
        wr_data = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] == AW'(r)) && !(ZERO_REG != 0 && r == 0)) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        busy_w    = busy_q & ~wr_hit;
        rsv_stall = rsv_en & busy_w[rsv_addr];
        rsv_ok    = rsv_en & ~rsv_stall & ((ZERO_REG == 0) || (rsv_addr != '0));
        busy_d    = busy_w;
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            mem_d[r] = wr_hit[r] ? wr_data[r] : mem_q[r];
            cnt_d    = cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          zero;
        assign a    = ra[i*AW +: AW];
        assign zero = (ZERO_REG != 0) && (a == '0);
        assign rd[i*XLEN +: XLEN] = zero ? '0 :
                                    ((BYPASS != 0) && wr_hit[a]) ? wr_data[a] : mem_q[a];
        // Busy as seen after this cycle's writes clear their targets.
        assign rbusy[i] = ~zero & busy_w[a];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core; next generation of the 32x32 2R1W file.
- Adds configurable width, depth and read/write port counts, optional write-to-read bypass, and a per-register busy scoreboard.
- The scoreboard tracks in-flight multi-cycle producers such as loads and divides. The decode stage uses it to detect RAW hazards (rbusy) and WAW hazards (rsv_stall).
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NREGS)
NRD, 2, number of read ports (>=1)
NWR, 1, number of write ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 hardwired to zero, its writes and reservations ignored

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
ra  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rbusy  out  NRD  port i target register currently busy (after same-cycle clear)
we  in  NWR  write enables
wa  in  NWR*AW  write addresses
wd  in  NWR*XLEN  write data
rsv_en  in  1  request to mark rsv_addr busy
rsv_addr  in  AW  register to reserve
rsv_stall  out  1  reservation refused this cycle (WAW)
busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Reset:
  - On rst_n low (asynchronous), all registers and all busy bits clear to 0, so busy_cnt=0.
  - After reset, rd returns 0 for every address and rbusy=0.
  - Reset mid-operation discards pending reservations; no write is taken on the edge where rst_n is low.
- Reads:
  - Combinational, zero latency.
  - ZERO_REG=1: address 0 always reads 0 and rbusy=0, regardless of writes or bypass.
- Bypass (BYPASS=1): if any we[j] is set with wa[j]==ra[i] (and not reg 0 when ZERO_REG), rd[i] returns that wd[j]. The highest-index matching write port wins.
- Writes:
  - Take effect on the rising clk edge.
  - Several ports writing the same address in one cycle: highest port index wins.
  - ZERO_REG=1: writes to address 0 are dropped.
  - A write to a non-busy register is legal and updates data.
- Scoreboard, per-register busy bit:
  - Set: accepted reservation.
  - Clear: any enabled write to that address.
  - A reservation is accepted when rsv_en=1, rsv_stall=0, and (ZERO_REG=0 or rsv_addr!=0). Its busy bit is set at the next edge.
  - rsv_stall = rsv_en & busy[rsv_addr] & ~(write to rsv_addr this cycle). It is combinational and refuses the reservation outright; the requester retries.
  - Same cycle, write clears and reservation sets the same address: the register ends busy, with the new producer in flight, and the written data is stored.
  - rbusy[i] reflects busy after this cycle's writes. A register being written this cycle reports rbusy=0 (consistent with bypass when BYPASS=1).
- busy_cnt:
  - Registered popcount of busy bits, updated each edge, same cycle as the bits.
  - Range 0..NREGS (or NREGS-1 with ZERO_REG). Width AW+1 prevents overflow at full occupancy.

Test Plan:
1. Pulse rst_n low, then sweep ra[0] over 0..31 -> rd=0, rbusy=0, busy_cnt=0 for every address.
2. Write wa=1, wd=42 for one edge, then read ra[0]=1 and ra[1]=1 -> both rd=42. Write wa=0, wd=122 -> rd for address 0 stays 0.
3. BYPASS=1: we=1, wa=5, wd=0xDEAD, ra[0]=5 in the same cycle -> rd[0]=0xDEAD before the edge. With BYPASS=0 the same stimulus -> rd[0]=old value (0) until after the edge.
4. NWR=2: both ports write address 7, wd[0]=1 and wd[1]=2, same edge -> register 7 reads 2.
5. Scoreboard RAW/WAW:
   - Reserve 3 -> next cycle busy_cnt=1 and rbusy for ra=3 is 1.
   - Reserve 3 again -> rsv_stall=1 and busy_cnt stays 1.
   - Write 3 with 9 -> rbusy=0 during that cycle, rd=9 with bypass, busy_cnt=0 after the edge.
   - Reserve 0 -> busy_cnt stays 0.
6. Register 4 busy, then one cycle with write 4 = 11 and reserve 4 -> rsv_stall=0, register 4 stays busy, reads 11, busy_cnt=1. Assert rst_n low mid-sequence -> busy_cnt=0 and all data 0 immediately.
